// File: rtl/input_decade_prescaler.sv
// input_decade_prescaler
// Front-end divider of the frequency meter, clocked by the measured input clock.
// Divides counting edges by 1/10/100/1000 while the synchronized gate is open,
// emits one cnt_pulse per completed ratio and freezes the BCD residue in HOLD.
// Optional feature: define CNT_TOGGLE_EN to drive cnt_toggle as a toggling copy
// of cnt_pulse for crossing into the slow clock domain; otherwise it is tied 0.
module input_decade_prescaler #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DECADES = 3
) (
    input  logic                     input_clk,
    input  logic                     reset,
    input  logic [1:0]               range_sel,
    input  logic                     gate,
    output logic                     gate_sync,
    output logic [1:0]               range_active,
    output logic                     cnt_pulse,
    output logic [4*NUM_DECADES-1:0] residue,
    output logic                     residue_valid,
    output logic                     cnt_toggle
);

    // Largest ratio index the digit chain can honour.
    localparam logic [1:0] LP_MAX_RANGE = 2'(NUM_DECADES > 3 ? 3 : NUM_DECADES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]         r_gate_ff;
    logic [SYNC_STAGES-1:0][1:0]    r_rng_ff;
    logic [1:0]                     r_rng_prev;
    logic [1:0]                     r_rng_stable;
    logic [1:0]                     w_rng_clamped;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [NUM_DECADES-1:0][3:0]    r_digits;
    logic [NUM_DECADES-1:0][3:0]    w_digits_next;
    logic [NUM_DECADES-1:0][3:0]    w_digits_inc;
    logic                           w_all_nine;
    logic                           w_carry;
    logic [1:0]                     r_range_active;
    logic [1:0]                     w_range_next;
    logic                           r_cnt_pulse;
    logic                           w_pulse_next;
    logic                           r_residue_valid;

    assign gate_sync     = r_gate_ff[SYNC_STAGES-1];
    assign range_active  = r_range_active;
    assign cnt_pulse     = r_cnt_pulse;
    assign residue       = r_digits;
    assign residue_valid = r_residue_valid;

    // Gate synchronizer chain; the last stage is the gate seen by the FSM.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_gate_ff <= '0;
        end else begin
            r_gate_ff <= {r_gate_ff[SYNC_STAGES-2:0], gate};
        end
    end

    // Range synchronizer plus compare register; stable value only follows two equal samples.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_rng_ff     <= '0;
            r_rng_prev   <= '0;
            r_rng_stable <= '0;
        end else begin
            r_rng_ff   <= {r_rng_ff[SYNC_STAGES-2:0], range_sel};
            r_rng_prev <= r_rng_ff[SYNC_STAGES-1];
            if (r_rng_ff[SYNC_STAGES-1] == r_rng_prev) begin
                r_rng_stable <= r_rng_prev;
            end
        end
    end

    // Clamp the requested ratio to the number of implemented decades.
    always_comb begin
        w_rng_clamped = r_rng_stable;
        if (r_rng_stable > LP_MAX_RANGE) begin
            w_rng_clamped = LP_MAX_RANGE;
        end
    end

    // BCD increment across the selected decades; all-nines marks a completed ratio.
    always_comb begin
        w_digits_inc = r_digits;
        w_all_nine   = 1'b1;
        w_carry      = 1'b1;
        for (int k = 0; k < NUM_DECADES; k++) begin
            if (k < int'(r_range_active)) begin
                if (r_digits[k] != 4'd9) begin
                    w_all_nine = 1'b0;
                end
                if (w_carry) begin
                    if (r_digits[k] == 4'd9) begin
                        w_digits_inc[k] = 4'd0;
                    end else begin
                        w_digits_inc[k] = r_digits[k] + 4'd1;
                        w_carry         = 1'b0;
                    end
                end
            end
        end
    end

    // FSM next state plus next values of digits, applied range and pulse.
    always_comb begin
        w_state_next  = r_state;
        w_digits_next = r_digits;
        w_range_next  = r_range_active;
        w_pulse_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_digits_next = '0;
                w_range_next  = w_rng_clamped;
                if (gate_sync) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                // Range stays frozen for the whole window.
                if (gate_sync) begin
                    w_digits_next = w_digits_inc;
                    w_pulse_next  = w_all_nine;
                end else begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_range_next = w_rng_clamped;
                if (gate_sync) begin
                    w_digits_next = '0;
                    w_state_next  = S_COUNT;
                end
            end
            default: begin
                w_digits_next = '0;
                w_state_next  = S_IDLE;
            end
        endcase
    end

    // FSM state register and datapath registers; residue_valid marks HOLD.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_digits        <= '0;
            r_range_active  <= '0;
            r_cnt_pulse     <= 1'b0;
            r_residue_valid <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_digits        <= w_digits_next;
            r_range_active  <= w_range_next;
            r_cnt_pulse     <= w_pulse_next;
            r_residue_valid <= (w_state_next == S_HOLD);
        end
    end

`ifdef CNT_TOGGLE_EN
    logic r_cnt_toggle;

    // Invert once per pulse cycle so a slow domain can detect pulses by edge.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_cnt_toggle <= 1'b0;
        end else if (r_cnt_pulse) begin
            r_cnt_toggle <= ~r_cnt_toggle;
        end
    end

    assign cnt_toggle = r_cnt_toggle;
`else
    assign cnt_toggle = 1'b0;
`endif

endmodule

// File: tb/tb_input_decade_prescaler.sv
// Testbench for input_decade_prescaler: directed windows plus random windows,
// checked every cycle against a count-based reference model.
module tb_input_decade_prescaler;

    localparam int SYNC = 2;
    localparam int ND   = 3;

    logic            input_clk = 1'b0;
    logic            reset     = 1'b0;
    logic [1:0]      range_sel = 2'd1;
    logic            gate      = 1'b0;
    logic            gate_sync;
    logic [1:0]      range_active;
    logic            cnt_pulse;
    logic [4*ND-1:0] residue;
    logic            residue_valid;
    logic            cnt_toggle;

    int n_checks = 0;
    int n_err    = 0;
    int pcount   = 0;
    int run      = 0;
    int maxrun   = 0;

    input_decade_prescaler #(.SYNC_STAGES(SYNC), .NUM_DECADES(ND)) dut (
        .input_clk    (input_clk),
        .reset        (reset),
        .range_sel    (range_sel),
        .gate         (gate),
        .gate_sync    (gate_sync),
        .range_active (range_active),
        .cnt_pulse    (cnt_pulse),
        .residue      (residue),
        .residue_valid(residue_valid),
        .cnt_toggle   (cnt_toggle)
    );

    always #5 input_clk = ~input_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] bcd(input int v);
        logic [31:0] r = '0;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [1:0] clamp(input logic [1:0] s);
        return (int'(s) > ND) ? 2'(ND) : s;
    endfunction

    // Reference model: window counter, ratio fixed at window start, residue = count mod ratio.
    int         m_mode = 0;   // 0 idle, 1 counting window, 2 holding result
    int         m_cnt  = 0;
    int         m_n    = 1;
    logic       m_gs   = 1'b0;
    logic       m_pulse = 1'b0;
    logic       m_tog  = 1'b0;
    logic       m_newp;
    logic [1:0] m_ra   = 2'd0;
    logic [1:0] m_stable = 2'd0;
    logic       g_hist [0:7];
    logic [1:0] r_hist [0:7];

    initial begin
        for (int i = 0; i < 8; i++) begin
            g_hist[i] = 1'b0;
            r_hist[i] = 2'd0;
        end
    end

    always @(posedge input_clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_n = 1; m_gs = 0; m_pulse = 0; m_tog = 0;
            m_ra = 0; m_stable = 0;
            for (int i = 0; i < 8; i++) begin
                g_hist[i] = 1'b0;
                r_hist[i] = 2'd0;
            end
        end else begin
            m_newp = 1'b0;
            if (m_mode == 1) begin
                if (m_gs) begin
                    m_cnt++;
                    m_newp = ((m_cnt % m_n) == 0);
                end else begin
                    m_mode = 2;
                end
            end else begin
                m_ra = clamp(m_stable);
                if (m_gs) begin
                    m_mode = 1;
                    m_cnt  = 0;
                    m_n    = pow10(int'(m_ra));
                end
            end
            if (m_pulse) m_tog = ~m_tog;
            m_pulse = m_newp;
            for (int i = 7; i > 0; i--) begin
                g_hist[i] = g_hist[i-1];
                r_hist[i] = r_hist[i-1];
            end
            g_hist[0] = gate;
            r_hist[0] = range_sel;
            m_gs     = g_hist[SYNC-1];
            m_stable = r_hist[SYNC+1];
        end
    end

    // Per-cycle comparison against the model, plus pulse statistics.
    always @(negedge input_clk) begin
        chk("gate_sync", 32'(gate_sync), 32'(m_gs));
        chk("range_active", 32'(range_active), 32'(m_ra));
        chk("cnt_pulse", 32'(cnt_pulse), 32'(m_pulse));
        chk("residue_valid", 32'(residue_valid), 32'(m_mode == 2));
        chk("residue", 32'(residue), bcd(m_cnt % m_n));
`ifdef CNT_TOGGLE_EN
        chk("cnt_toggle", 32'(cnt_toggle), 32'(m_tog));
`else
        chk("cnt_toggle", 32'(cnt_toggle), 32'd0);
`endif
        if (cnt_pulse) begin
            pcount++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    task automatic tick();
        @(posedge input_clk);
        #2;
    endtask

    // Open the gate long enough for exactly n counting edges, then close and settle in HOLD.
    task automatic window(input int n);
        gate = 1'b1;
        repeat (n + 1) tick();
        gate = 1'b0;
        repeat (SYNC + 4) tick();
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) tick();
        chk("reset_residue", 32'(residue), 32'd0);
        chk("reset_gate_sync", 32'(gate_sync), 32'd0);
        reset = 1'b0;
        repeat (8) tick();

        // Divide by 10, 25 counting edges.
        pcount = 0;
        window(25);
        chk("t1_pulses", pcount, 2);
        chk("t1_residue", 32'(residue), 32'h005);
        chk("t1_valid", 32'(residue_valid), 32'd1);
        chk("t6_toggle", 32'(cnt_toggle), 32'd0);

        // Divide by 1, 7 counting edges.
        range_sel = 2'd0;
        repeat (8) tick();
        pcount = 0; maxrun = 0;
        window(7);
        chk("t2_pulses", pcount, 7);
        chk("t2_run", maxrun, 7);
        chk("t2_residue", 32'(residue), 32'h000);

        // Divide by 1000, 2500 counting edges.
        range_sel = 2'd3;
        repeat (8) tick();
        pcount = 0;
        window(2500);
        chk("t3_pulses", pcount, 2);
        chk("t3_residue", 32'(residue), 32'h500);

        // Range change during a window is deferred to HOLD.
        range_sel = 2'd1;
        repeat (8) tick();
        pcount = 0;
        gate = 1'b1;
        repeat (15) tick();
        range_sel = 2'd2;
        repeat (20) tick();
        chk("t4_range_frozen", 32'(range_active), 32'd1);
        gate = 1'b0;
        repeat (SYNC + 4) tick();
        chk("t4_range_hold", 32'(range_active), 32'd2);
        chk("t4_pulses", pcount, 3);
        chk("t4_residue", 32'(residue), 32'h004);
        pcount = 0;
        window(150);
        chk("t4_next_pulses", pcount, 1);
        chk("t4_next_residue", 32'(residue), 32'h050);

        // Asynchronous reset in the middle of a window.
        gate = 1'b1;
        repeat (50) tick();
        chk("t5_pre_residue", 32'(residue), 32'h047);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_residue", 32'(residue), 32'd0);
        chk("t5_rst_pulse", 32'(cnt_pulse), 32'd0);
        chk("t5_rst_valid", 32'(residue_valid), 32'd0);
        chk("t5_rst_range", 32'(range_active), 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("t5_no_pulse_yet", 32'(cnt_pulse), 32'd0);
        tick();
        chk("t5_first_pulse", 32'(cnt_pulse), 32'd1);
        gate = 1'b0;
        repeat (10) tick();

        // Random windows and ratios.
        for (int it = 0; it < 14; it++) begin
            range_sel = 2'($urandom_range(0, 3));
            repeat (8) tick();
            window($urandom_range(0, 300));
            repeat ($urandom_range(0, 5)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/input_decade_prescaler.md
Name: input_decade_prescaler

Overview:
- Front-end stage in the input_clk domain. It feeds the decimal pulse counter of the frequency meter.
- Divides the external input clock by a decade ratio of 1, 10, 100 or 1000. Counts only while the measurement gate is open.
- Emits one count pulse per completed ratio. After the gate closes, it exposes the BCD residue of the last incomplete ratio so the downstream stage can display the extended-range result.

Parameters:
SYNC_STAGES, 2, number of flops in each async-to-input_clk synchronizer (min 2)
NUM_DECADES, 3, number of BCD divider decades; maximum ratio is 10^NUM_DECADES

Ports:
input_clk  in  1  measured external clock; all logic is clocked on its rising edge
reset  in  1  asynchronous, active-high reset
range_sel  in  2  requested ratio, driven from the clk domain, quasi-static: 0=÷1, 1=÷10, 2=÷100, 3=÷1000
gate  in  1  measurement window from the clk domain, level, high=open
gate_sync  out  1  synchronized gate (last synchronizer stage)
range_active  out  2  ratio currently applied
cnt_pulse  out  1  one-cycle pulse per completed ratio
residue  out  4*NUM_DECADES  frozen BCD divider digits; digit0 is at the LSBs
residue_valid  out  1  high in HOLD

Behaviour:
- Reset (async assert): all synchronizer flops, digits, cnt_pulse, residue_valid, range_active=0, gate_sync=0, state=IDLE.
- Reset is asserted/released asynchronously; logic resumes on the first input_clk edge after release.
- gate synchronizer: SYNC_STAGES flops in series. gate_sync is the last stage.
- range_sel synchronizer: SYNC_STAGES flops per bit plus one compare register.
  - rng_stable is updated only when two consecutive synced samples are equal.
- Clamp: if rng_stable > NUM_DECADES, the applied value is NUM_DECADES.
- FSM states: IDLE, COUNT, HOLD.
  - IDLE: digits=0, residue_valid=0. range_active<=clamped rng_stable every edge. When gate_sync=1: digits<=0, go to COUNT.
  - COUNT: range_active is frozen.
    - Edge with gate_sync=1: counting edge; the low range_active digits increment as a BCD cascade.
    - Edge with gate_sync=0: no increment, go to HOLD.
  - HOLD: digits frozen, residue_valid=1, range_active<=clamped rng_stable every edge. When gate_sync=1: digits<=0, residue_valid<=0, go to COUNT.
- BCD cascade:
  - Digit k wraps 9->0 and carries into digit k+1, for k < range_active-1.
  - When all selected digits are 9 on a counting edge, all selected digits wrap to 0.
  - Unselected digits are held at 0.
- cnt_pulse (registered):
  - Next-cycle value is 1 when the current edge is a counting edge and either range_active=0, or all selected digits equal 9.
  - Otherwise 0.
  - With ÷N, the Nth, 2Nth, … counting edges each produce one pulse, visible for the cycle after that edge.
- residue equals the digit registers at all times. It is defined only while residue_valid=1.
- Latency:
  - gate rise to state COUNT: SYNC_STAGES+1 input_clk edges.
  - The first counting edge is the one after that.
- Simultaneous events:
  - gate_sync falling on the same edge a ratio would complete: no increment and no pulse; the digits stay at N-1.
  - range_sel changing during COUNT: takes effect only in HOLD/IDLE.
- No wrap beyond the top selected decade; the ratio counter simply restarts.

Optional Feature:
- Macro: CNT_TOGGLE_EN.
- When defined:
  - Adds output cnt_toggle, width 1, reset 0.
  - It inverts on every cycle in which cnt_pulse=1, for CDC into the slow clk domain.
- When undefined:
  - The port still exists and is tied 0.
  - No extra flops.

Test Plan:
1. Range 1 (÷10), gate high for 25 counting edges, then low -> cnt_pulse after the 10th and 20th counting edges only. In HOLD, residue=0x005 and residue_valid=1.
2. Range 0, 7 counting edges -> 7 consecutive single-cycle pulses (cnt_pulse continuously high for 7 cycles). residue=0x000.
3. Range 3, NUM_DECADES=3, 2500 counting edges -> exactly 2 pulses. residue=0x500.
4. range_sel 1->2 while in COUNT -> range_active stays 1 until HOLD. It becomes 2 within SYNC_STAGES+2 edges after entering HOLD. The next window divides by 100.
5. Reset asserted mid-COUNT with digits=0x047 -> immediately digits=0, cnt_pulse=0, residue_valid=0, state IDLE. After release with gate high, COUNT is entered after SYNC_STAGES+1 edges.
6. CNT_TOGGLE_EN defined, rerun test 1 -> cnt_toggle goes 0->1->0 (two toggles). Macro undefined -> cnt_toggle constantly 0.
